// File: rtl/stash_writeback_scanner_if.sv
// Slot stream from the write-back scanner to the path writeback datapath.
// The scanner drives the master side; the datapath drives OutReady.
interface stash_writeback_scanner_if #(
  parameter int unsigned ORAML        = 31,
  parameter int unsigned StashEAWidth = 7,
  localparam int unsigned LevelWidth  = $clog2(ORAML + 1)
);
  logic [StashEAWidth-1:0] OutSAddr;
  logic                    OutReal;
  logic [LevelWidth-1:0]   OutLevel;
  logic                    OutValid;
  logic                    OutReady;

  modport master (output OutSAddr, OutReal, OutLevel, OutValid, input OutReady);
  modport slave  (input OutSAddr, OutReal, OutLevel, OutValid, output OutReady);
endinterface

// File: rtl/stash_writeback_scanner.sv
// Walks the stash scan table leaf-to-root after a scan, emitting one slot per
// bucket entry to the writeback datapath and clearing each entry as it is read.
module stash_writeback_scanner #(
  parameter int unsigned ORAML        = 31,
  parameter int unsigned ORAMZ        = 4,
  parameter int unsigned ZSlotWidth   = 2,
  parameter int unsigned StashEAWidth = 7,
  localparam int unsigned ORAMLP1         = ORAML + 1,
  localparam int unsigned LevelWidth      = $clog2(ORAMLP1),
  localparam int unsigned ScanTableAWidth = LevelWidth + ZSlotWidth
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       TableReady,
  input  logic                       Start,
  output logic [ScanTableAWidth-1:0] InSTAddr,
  output logic                       InSTValid,
  output logic                       InSTReset,
  input  logic [StashEAWidth-1:0]    OutSTAddr,
  input  logic                       OutSTValid,
  stash_writeback_scanner_if.master  out_if,
  output logic                       Busy,
  output logic                       Done,
  output logic [ScanTableAWidth:0]   RealCount
);

  localparam int unsigned RcWidth = ScanTableAWidth + 1;
  localparam logic [StashEAWidth-1:0] SNULL    = '1;
  localparam logic [RcWidth-1:0]      MaxReal  = RcWidth'(ORAMZ * ORAMLP1);
  localparam logic [LevelWidth-1:0]   TopLevel = LevelWidth'(ORAML);
  localparam logic [ZSlotWidth-1:0]   LastSlot = ZSlotWidth'(ORAMZ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CLEAR,
    S_EMIT,
    S_DONE
  } state_e;

  state_e                     state_q;
  logic [LevelWidth-1:0]      level_q, level_d;
  logic [ZSlotWidth-1:0]      slot_q, slot_d;
  logic [ScanTableAWidth-1:0] st_addr_q;
  logic                       st_valid_q, st_reset_q;
  logic [StashEAWidth-1:0]    saddr_q;
  logic                       real_q;
  logic                       out_valid_q;
  logic                       busy_q, done_q;
  logic [RcWidth-1:0]         real_cnt_q, real_cnt_d;
  logic                       accept, slot_last, walk_end;

  always_comb begin
    accept     = out_valid_q & out_if.OutReady;
    slot_last  = (slot_q == LastSlot);
    slot_d     = slot_last ? '0 : slot_q + 1'b1;
    level_d    = slot_last ? level_q - 1'b1 : level_q;
    walk_end   = slot_last && (level_q == '0);
    real_cnt_d = (real_q && (real_cnt_q != MaxReal)) ? real_cnt_q + 1'b1 : real_cnt_q;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      slot_q      <= '0;
      st_addr_q   <= '0;
      st_valid_q  <= 1'b0;
      st_reset_q  <= 1'b0;
      saddr_q     <= SNULL;
      real_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      real_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start && TableReady) begin
            state_q    <= S_READ;
            level_q    <= TopLevel;
            slot_q     <= '0;
            real_cnt_q <= '0;
            st_addr_q  <= {TopLevel, {ZSlotWidth{1'b0}}};
            st_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_READ: begin
          st_valid_q <= 1'b0;
          st_reset_q <= 1'b1;
          state_q    <= S_CLEAR;
        end
        S_CLEAR: begin
          // Missing read data is treated as a dummy slot rather than a bogus address.
          st_reset_q  <= 1'b0;
          saddr_q     <= OutSTValid ? OutSTAddr : SNULL;
          real_q      <= OutSTValid && (OutSTAddr != SNULL);
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            real_q      <= 1'b0;
            saddr_q     <= SNULL;
            real_cnt_q  <= real_cnt_d;
            if (walk_end) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              slot_q     <= slot_d;
              level_q    <= level_d;
              st_addr_q  <= {level_d, slot_d};
              st_valid_q <= 1'b1;
              state_q    <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign InSTAddr        = st_addr_q;
  assign InSTValid       = st_valid_q;
  assign InSTReset       = st_reset_q;
  assign out_if.OutSAddr = saddr_q;
  assign out_if.OutReal  = real_q;
  assign out_if.OutLevel = level_q;
  assign out_if.OutValid = out_valid_q;
  assign Busy            = busy_q;
  assign Done            = done_q;
  assign RealCount       = real_cnt_q;

endmodule

// File: tb/tb_stash_writeback_scanner.sv
// Scoreboard bench for stash_writeback_scanner with a behavioural scan table.
module tb_stash_writeback_scanner;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       TableReady = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] InSTAddr;
  logic       InSTValid, InSTReset;
  logic [6:0] OutSTAddr;
  logic       OutSTValid;
  logic       Busy, Done;
  logic [4:0] RealCount;

  stash_writeback_scanner_if #(.ORAML(3), .StashEAWidth(7)) sif ();

  stash_writeback_scanner #(
    .ORAML(3), .ORAMZ(4), .ZSlotWidth(2), .StashEAWidth(7)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .TableReady(TableReady), .Start(Start),
    .InSTAddr(InSTAddr), .InSTValid(InSTValid), .InSTReset(InSTReset),
    .OutSTAddr(OutSTAddr), .OutSTValid(OutSTValid), .out_if(sif),
    .Busy(Busy), .Done(Done), .RealCount(RealCount)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scan table model: registered read, clear strobe writes SNULL.
  logic [6:0] mem [16];
  logic [6:0] pre [16];
  logic       load = 1'b0;

  always @(posedge Clock) begin
    if (load) mem <= pre;
    else begin
      OutSTValid <= InSTValid;
      if (InSTValid) OutSTAddr <= mem[InSTAddr];
      if (InSTReset) mem[InSTAddr] <= 7'd127;
    end
  end

  typedef struct {
    logic [6:0] saddr;
    logic       isreal;
    logic [1:0] level;
  } exp_t;

  exp_t       sq[$];
  logic [3:0] aq[$];
  logic [6:0] exp_tab [16];
  logic [3:0] exp_last = '0;
  int slot_idx = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stalled = 0;
  int done_cnt = 0;

  always @(negedge Clock) begin
    logic rdy;
    exp_t e;
    rdy = 1'b1;
    if (!Reset_n) begin
      sq.delete();
      aq.delete();
    end
    if (Done) done_cnt++;
    if (InSTValid | InSTReset) chk("strobe_excl", {31'd0, InSTValid & InSTReset}, 0);
    if (InSTValid) begin
      if (aq.size() == 0) chk("st_addr_unexpected", {28'd0, InSTAddr}, 32'hFFFF);
      else begin
        exp_last = aq.pop_front();
        chk("st_addr", {28'd0, InSTAddr}, {28'd0, exp_last});
      end
    end
    if (InSTReset) chk("clr_addr", {28'd0, InSTAddr}, {28'd0, exp_last});
    if (sif.OutValid) begin
      if (sq.size() == 0) chk("out_unexpected", {31'd0, sif.OutValid}, 0);
      else if (slot_idx == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
        chk("stall_saddr", {25'd0, sif.OutSAddr}, {25'd0, sq[0].saddr});
        chk("stall_level", {30'd0, sif.OutLevel}, {30'd0, sq[0].level});
        chk("stall_table_idle", {31'd0, InSTValid | InSTReset}, 0);
      end else begin
        e = sq.pop_front();
        chk("out_saddr", {25'd0, sif.OutSAddr}, {25'd0, e.saddr});
        chk("out_real", {31'd0, sif.OutReal}, {31'd0, e.isreal});
        chk("out_level", {30'd0, sif.OutLevel}, {30'd0, e.level});
        slot_idx++;
        stalled = 0;
      end
    end
    sif.OutReady = rdy;
  end

  task automatic load_tab();
    load = 1'b1;
    @(posedge Clock);
    #1 load = 1'b0;
  endtask

  task automatic set_tabs(input logic [6:0] a12, input logic [6:0] a9, input logic [6:0] a0);
    for (int i = 0; i < 16; i++) begin
      pre[i] = 7'd127;
      exp_tab[i] = 7'd127;
    end
    pre[12] = a12; exp_tab[12] = a12;
    pre[9]  = a9;  exp_tab[9]  = a9;
    pre[0]  = a0;  exp_tab[0]  = a0;
  endtask

  // Leaf-first walk order: level 3..0, slots 0..3 within each bucket.
  task automatic push_exp();
    exp_t e;
    for (int l = 3; l >= 0; l--) begin
      for (int s = 0; s < 4; s++) begin
        e.saddr  = exp_tab[l*4+s];
        e.isreal = (exp_tab[l*4+s] != 7'd127);
        e.level  = 2'(l);
        sq.push_back(e);
        aq.push_back(4'(l*4+s));
      end
    end
  endtask

  task automatic run_walk(input int exp_cyc, input int exp_rc, input bit mid_start);
    int cyc;
    push_exp();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    cyc = 1;
    while (!Done && cyc < 400) begin
      Start = mid_start && (cyc == 20);
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    chk("done_latency", cyc, exp_cyc);
    chk("real_count", {27'd0, RealCount}, exp_rc);
    chk("sb_empty", sq.size(), 0);
    chk("addr_q_empty", aq.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", {31'd0, sif.OutValid}, 0);
    chk("rst_out_saddr", {25'd0, sif.OutSAddr}, 127);
    chk("rst_out_real", {31'd0, sif.OutReal}, 0);
    chk("rst_out_level", {30'd0, sif.OutLevel}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_real_count", {27'd0, RealCount}, 0);
    chk("rst_st_valid", {31'd0, InSTValid}, 0);
    chk("rst_st_reset", {31'd0, InSTReset}, 0);
  endtask

  initial begin
    int d0;
    set_tabs(7'd127, 7'd127, 7'd127);
    load_tab();
    @(negedge Clock);
    check_reset_outputs();
    Reset_n = 1'b1;

    // All-dummy walk
    run_walk(49, 0, 1'b0);

    // Three real entries, then the table must be clean
    set_tabs(7'd5, 7'd17, 7'd42);
    load_tab();
    run_walk(49, 3, 1'b0);
    for (int i = 0; i < 16; i++) chk("table_clean", {25'd0, mem[i]}, 127);

    // 10-cycle stall on the slot carrying 17
    load_tab();
    stall_len = 10;
    stall_at = slot_idx + 5;
    run_walk(59, 3, 1'b0);
    stall_len = 0;

    // Start without TableReady, then Start mid-walk
    set_tabs(7'd127, 7'd127, 7'd127);
    TableReady = 1'b0;
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(negedge Clock);
    chk("ignored_busy", {31'd0, Busy}, 0);
    chk("ignored_st_valid", {31'd0, InSTValid}, 0);
    TableReady = 1'b1;
    d0 = done_cnt;
    run_walk(49, 0, 1'b1);
    repeat (5) @(negedge Clock);
    chk("single_walk_busy", {31'd0, Busy}, 0);
    chk("single_done", done_cnt - d0, 1);

    // Async reset during EMIT of the fifth slot
    set_tabs(7'd127, 7'd17, 7'd42);
    load_tab();
    push_exp();
    d0 = done_cnt;
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (14) @(negedge Clock);
    #2;
    chk("pre_abort_valid", {31'd0, sif.OutValid}, 1);
    chk("pre_abort_level", {30'd0, sif.OutLevel}, 2);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge Clock);
    chk("abort_no_done", done_cnt - d0, 0);
    Reset_n = 1'b1;
    run_walk(49, 2, 1'b0);

    // Back-to-back: second walk must see the clears from the first
    set_tabs(7'd5, 7'd127, 7'd127);
    load_tab();
    run_walk(49, 1, 1'b0);
    set_tabs(7'd127, 7'd127, 7'd127);
    run_walk(49, 0, 1'b0);

    repeat (3) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
